mismatch_monitor: RTL and testbench

//  Downstream consumer of the 3-stage byte-compare pipeline's 1-bit mismatch flag.

---
 rtl/mismatch_monitor.sv | 177 +++++++++++++++++
 tb/tb_mismatch_monitor.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mismatch_monitor.sv
// Mismatch monitor for the compare pipeline: hides pipeline fill, counts total and per-window hits, sticky alarm.
// Optional consecutive-run alarm is built when MISMATCH_RUN_DET_EN is defined; otherwise run_alarm is tied to 0.
module mismatch_monitor #(
    parameter int FILL_LAT = 3,
    parameter int WIN_LEN  = 16,
    parameter int ALARM_TH = 4,
    parameter int CNT_W    = 8,
    parameter int RUN_TH   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             mis_in,
    output logic [CNT_W-1:0] mis_cnt,
    output logic [CNT_W-1:0] win_cnt,
    output logic             win_done,
    output logic             alarm,
    output logic [1:0]       state,
    output logic             run_alarm
);
    typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2, ALARM = 2'd3} state_t;

    localparam int FP_W = (FILL_LAT > 1) ? $clog2(FILL_LAT) : 1;
    localparam logic [FP_W-1:0]  FILL_LAST  = FP_W'(FILL_LAT - 1);
    localparam logic [CNT_W-1:0] WIN_LAST   = CNT_W'(WIN_LEN - 1);
    localparam logic [CNT_W-1:0] ALARM_TH_C = CNT_W'(ALARM_TH);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t            state_reg, state_next;
    logic [FP_W-1:0]   fill_pos_reg, fill_pos_next;
    logic [CNT_W-1:0]  win_pos_reg, win_pos_next;
    logic [CNT_W-1:0]  acc_reg, acc_next;
    logic [CNT_W-1:0]  mis_cnt_reg, mis_cnt_next;
    logic [CNT_W-1:0]  win_cnt_reg, win_cnt_next;
    logic              win_done_reg, win_done_next;
    logic              alarm_reg, alarm_next;
    logic              count_en;
    logic [CNT_W-1:0]  acc_sum;

    // acc never exceeds WIN_LEN-1 before the add, so the sum fits in CNT_W bits
    assign acc_sum = acc_reg + CNT_W'(mis_in);

    always_comb begin
        state_next    = state_reg;
        fill_pos_next = fill_pos_reg;
        win_pos_next  = win_pos_reg;
        acc_next      = acc_reg;
        mis_cnt_next  = mis_cnt_reg;
        win_cnt_next  = win_cnt_reg;
        win_done_next = 1'b0;
        count_en      = 1'b0;

        if (clr) begin
            state_next    = IDLE;
            fill_pos_next = '0;
            win_pos_next  = '0;
            acc_next      = '0;
            mis_cnt_next  = '0;
            win_cnt_next  = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (en) begin
                        state_next    = FILL;
                        fill_pos_next = '0;
                    end
                end
                FILL: begin
                    if (!en) begin
                        state_next = IDLE;
                    end else if (fill_pos_reg == FILL_LAST) begin
                        state_next   = RUN;
                        win_pos_next = '0;
                        acc_next     = '0;
                    end else begin
                        fill_pos_next = fill_pos_reg + 1'b1;
                    end
                end
                RUN: begin
                    if (!en) begin
                        state_next   = IDLE;
                        win_pos_next = '0;
                        acc_next     = '0;
                    end else begin
                        count_en = 1'b1;
                        if (win_pos_reg == WIN_LAST) begin
                            win_cnt_next  = acc_sum;
                            win_done_next = 1'b1;
                            acc_next      = '0;
                            win_pos_next  = '0;
                            if (acc_sum >= ALARM_TH_C)
                                state_next = ALARM;
                        end else begin
                            acc_next     = acc_sum;
                            win_pos_next = win_pos_reg + 1'b1;
                        end
                    end
                end
                ALARM: begin
                    // window logic frozen; only the total keeps counting
                    count_en = 1'b1;
                end
                default: state_next = IDLE;
            endcase
        end

        if (count_en && mis_in && (mis_cnt_reg != CNT_MAX))
            mis_cnt_next = mis_cnt_reg + 1'b1;

        alarm_next = (state_next == ALARM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            fill_pos_reg <= '0;
            win_pos_reg  <= '0;
            acc_reg      <= '0;
            mis_cnt_reg  <= '0;
            win_cnt_reg  <= '0;
            win_done_reg <= 1'b0;
            alarm_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            fill_pos_reg <= fill_pos_next;
            win_pos_reg  <= win_pos_next;
            acc_reg      <= acc_next;
            mis_cnt_reg  <= mis_cnt_next;
            win_cnt_reg  <= win_cnt_next;
            win_done_reg <= win_done_next;
            alarm_reg    <= alarm_next;
        end
    end

    assign state    = state_reg;
    assign mis_cnt  = mis_cnt_reg;
    assign win_cnt  = win_cnt_reg;
    assign win_done = win_done_reg;
    assign alarm    = alarm_reg;

`ifdef MISMATCH_RUN_DET_EN
    localparam int RC_W = $clog2(RUN_TH + 1);
    localparam logic [RC_W-1:0] RUN_TH_C = RC_W'(RUN_TH);

    logic [RC_W-1:0] run_cnt_reg, run_cnt_next;
    logic            run_alarm_reg, run_alarm_next;

    // streak counter saturates at RUN_TH; it is zero outside RUN/ALARM
    always_comb begin
        run_cnt_next   = '0;
        run_alarm_next = run_alarm_reg;
        if (clr) begin
            run_alarm_next = 1'b0;
        end else if (count_en && mis_in) begin
            run_cnt_next = (run_cnt_reg == RUN_TH_C) ? run_cnt_reg : run_cnt_reg + 1'b1;
            if (run_cnt_next == RUN_TH_C)
                run_alarm_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt_reg   <= '0;
            run_alarm_reg <= 1'b0;
        end else begin
            run_cnt_reg   <= run_cnt_next;
            run_alarm_reg <= run_alarm_next;
        end
    end

    assign run_alarm = run_alarm_reg;
`else
    // RUN_TH has no effect in this build; the comparison is constant 0 for any legal RUN_TH
    assign run_alarm = (RUN_TH < 0);
`endif
endmodule

// File: tb/tb_mismatch_monitor.sv
// Bench for mismatch_monitor: directed scenarios plus randomized traffic against a behavioural model.
module tb_mismatch_monitor;
    localparam int FILL_LAT = 3;
    localparam int WIN_LEN  = 16;
    localparam int ALARM_TH = 4;
    localparam int CNT_W    = 8;
    localparam int RUN_TH   = 3;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;
`ifdef MISMATCH_RUN_DET_EN
    localparam bit RUN_DET = 1'b1;
`else
    localparam bit RUN_DET = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0, clr = 1'b0, mis_in = 1'b0;
    logic [CNT_W-1:0] mis_cnt, win_cnt;
    logic win_done, alarm, run_alarm;
    logic [1:0] state;

    logic s_en = 1'b0, s_clr = 1'b0, s_mis = 1'b0;
    logic [3:0] s_mis_cnt, s_win_cnt;
    logic s_win_done, s_alarm, s_run_alarm;
    logic [1:0] s_state;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mismatch_monitor #(.FILL_LAT(FILL_LAT), .WIN_LEN(WIN_LEN), .ALARM_TH(ALARM_TH),
                       .CNT_W(CNT_W), .RUN_TH(RUN_TH)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mis_in(mis_in),
        .mis_cnt(mis_cnt), .win_cnt(win_cnt), .win_done(win_done),
        .alarm(alarm), .state(state), .run_alarm(run_alarm)
    );

    mismatch_monitor #(.FILL_LAT(3), .WIN_LEN(15), .ALARM_TH(15), .CNT_W(4), .RUN_TH(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .en(s_en), .clr(s_clr), .mis_in(s_mis),
        .mis_cnt(s_mis_cnt), .win_cnt(s_win_cnt), .win_done(s_win_done),
        .alarm(s_alarm), .state(s_state), .run_alarm(s_run_alarm)
    );

    // Behavioural model: mode code as defined for the state output, plus plain counters
    int m_mode, m_fill_seen, m_samples, m_hits, m_total, m_last_win, m_streak;
    bit m_done, m_streak_alarm;

    function automatic void model_reset();
        m_mode = 0; m_fill_seen = 0; m_samples = 0; m_hits = 0;
        m_total = 0; m_last_win = 0; m_streak = 0;
        m_done = 1'b0; m_streak_alarm = 1'b0;
    endfunction

    function automatic void model_count(bit m);
        m_total = (m_total + int'(m) > CNT_MAX) ? CNT_MAX : m_total + int'(m);
        if (RUN_DET) begin
            m_streak = m ? m_streak + 1 : 0;
            if (m_streak >= RUN_TH) m_streak_alarm = 1'b1;
        end
    endfunction

    function automatic void model_step(bit e, bit c, bit m);
        m_done = 1'b0;
        if (c) begin
            model_reset();
            return;
        end
        case (m_mode)
            0: if (e) begin m_mode = 1; m_fill_seen = 0; end
            1: begin
                if (!e) m_mode = 0;
                else begin
                    m_fill_seen++;
                    if (m_fill_seen == FILL_LAT) begin m_mode = 2; m_samples = 0; m_hits = 0; end
                end
            end
            2: begin
                if (!e) begin
                    m_mode = 0; m_samples = 0; m_hits = 0; m_streak = 0;
                end else begin
                    model_count(m);
                    m_samples++;
                    m_hits += int'(m);
                    if (m_samples == WIN_LEN) begin
                        m_last_win = m_hits;
                        m_done = 1'b1;
                        if (m_hits >= ALARM_TH) m_mode = 3;
                        m_samples = 0; m_hits = 0;
                    end
                end
            end
            default: model_count(m);
        endcase
    endfunction

    task automatic tick(input bit e, input bit c, input bit m);
        en = e; clr = c; mis_in = m;
        @(posedge clk);
        model_step(e, c, m);
        #1;
    endtask

    task automatic enter_run();
        tick(0, 1, 0);
        tick(1, 0, 0);
        repeat (FILL_LAT) tick(1, 0, 0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 0; clr = 0; mis_in = 0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({mis_cnt, win_cnt, win_done, alarm, state, run_alarm} !== '0) begin
            n_err++;
            $display("FAIL reset_init: outputs=%h required 0", {mis_cnt, win_cnt, win_done, alarm, state, run_alarm});
        end
        rst_n = 1'b1;
        model_reset();
        tick(1, 0, 0);
        repeat (FILL_LAT) tick(1, 0, 0);
        repeat (5) tick(1, 0, 1);
        n_vec++;
        if (state !== 2'd2 || mis_cnt !== 8'd5) begin
            n_err++;
            $display("FAIL reset_prep: state=%0d mis_cnt=%0d required 2/5", state, mis_cnt);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({mis_cnt, win_cnt, win_done, alarm, state, run_alarm} !== '0) begin
            n_err++;
            $display("FAIL reset_async: outputs=%h required 0 before any edge", {mis_cnt, win_cnt, win_done, alarm, state, run_alarm});
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        tick(0, 0, 1);
        n_vec++;
        if (state !== 2'd0 || mis_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL reset_release: state=%0d mis_cnt=%0d required 0/0", state, mis_cnt);
        end
    endtask

    task automatic test_fill_ignore();
        tick(0, 1, 0);
        tick(1, 0, 1);
        for (int i = 0; i < FILL_LAT; i++) begin
            tick(1, 0, 1);
            n_vec++;
            if (state !== ((i == FILL_LAT - 1) ? 2'd2 : 2'd1)) begin
                n_err++;
                $display("FAIL fill_state[%0d]: state=%0d required %0d", i, state, (i == FILL_LAT - 1) ? 2 : 1);
            end
        end
        for (int i = 0; i < WIN_LEN; i++) begin
            tick(1, 0, 0);
            if (i >= WIN_LEN - 2) begin
                n_vec++;
                if (win_done !== (i == WIN_LEN - 1)) begin
                    n_err++;
                    $display("FAIL fill_win_done[%0d]: win_done=%0b required %0b", i, win_done, i == WIN_LEN - 1);
                end
            end
        end
        n_vec++;
        if (win_cnt !== 8'd0 || mis_cnt !== 8'd0 || alarm !== 1'b0) begin
            n_err++;
            $display("FAIL fill_ignore: win_cnt=%0d mis_cnt=%0d alarm=%0b required 0/0/0", win_cnt, mis_cnt, alarm);
        end
        tick(1, 0, 0);
        n_vec++;
        if (win_done !== 1'b0) begin
            n_err++;
            $display("FAIL fill_pulse_width: win_done=%0b required 0", win_done);
        end
    endtask

    task automatic test_alarm_window();
        enter_run();
        for (int i = 0; i < WIN_LEN; i++) tick(1, 0, (i % 5) == 1);
        n_vec++;
        if (win_cnt !== 8'd3 || alarm !== 1'b0 || state !== 2'd2 || win_done !== 1'b1) begin
            n_err++;
            $display("FAIL alarm_win1: win_cnt=%0d alarm=%0b state=%0d win_done=%0b required 3/0/2/1", win_cnt, alarm, state, win_done);
        end
        for (int i = 0; i < WIN_LEN; i++) begin
            tick(1, 0, (i % 4) == 0);
            if (i == WIN_LEN - 2) begin
                n_vec++;
                if (state !== 2'd2 || alarm !== 1'b0) begin
                    n_err++;
                    $display("FAIL alarm_early: state=%0d alarm=%0b required 2/0", state, alarm);
                end
            end
        end
        n_vec++;
        if (win_cnt !== 8'd4 || alarm !== 1'b1 || state !== 2'd3 || mis_cnt !== 8'd7) begin
            n_err++;
            $display("FAIL alarm_trip: win_cnt=%0d alarm=%0b state=%0d mis_cnt=%0d required 4/1/3/7", win_cnt, alarm, state, mis_cnt);
        end
        repeat (3) tick(0, 0, 1);
        n_vec++;
        if (alarm !== 1'b1 || state !== 2'd3 || mis_cnt !== 8'd10 || win_cnt !== 8'd4 || win_done !== 1'b0) begin
            n_err++;
            $display("FAIL alarm_sticky: alarm=%0b state=%0d mis_cnt=%0d win_cnt=%0d win_done=%0b required 1/3/10/4/0",
                     alarm, state, mis_cnt, win_cnt, win_done);
        end
        tick(0, 1, 0);
        n_vec++;
        if (state !== 2'd0 || mis_cnt !== 8'd0 || alarm !== 1'b0 || win_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL alarm_clr: state=%0d mis_cnt=%0d alarm=%0b win_cnt=%0d required 0/0/0/0", state, mis_cnt, alarm, win_cnt);
        end
    endtask

    task automatic test_en_drop();
        enter_run();
        for (int i = 0; i < WIN_LEN; i++) tick(1, 0, i == 3);
        for (int i = 0; i < 9; i++) tick(1, 0, (i == 1) || (i == 5));
        tick(0, 0, 1);
        n_vec++;
        if (state !== 2'd0 || win_cnt !== 8'd1 || mis_cnt !== 8'd3) begin
            n_err++;
            $display("FAIL drop_idle: state=%0d win_cnt=%0d mis_cnt=%0d required 0/1/3", state, win_cnt, mis_cnt);
        end
        tick(1, 0, 0);
        for (int i = 0; i < FILL_LAT; i++) begin
            n_vec++;
            if (state !== 2'd1) begin
                n_err++;
                $display("FAIL drop_refill[%0d]: state=%0d required 1", i, state);
            end
            tick(1, 0, 0);
        end
        for (int i = 0; i < WIN_LEN; i++) begin
            tick(1, 0, i == 0);
            if (i == WIN_LEN - 2) begin
                n_vec++;
                if (win_done !== 1'b0) begin
                    n_err++;
                    $display("FAIL drop_early_done: win_done=%0b required 0", win_done);
                end
            end
        end
        n_vec++;
        if (win_cnt !== 8'd1 || win_done !== 1'b1 || mis_cnt !== 8'd4) begin
            n_err++;
            $display("FAIL drop_fresh_window: win_cnt=%0d win_done=%0b mis_cnt=%0d required 1/1/4", win_cnt, win_done, mis_cnt);
        end
    endtask

    task automatic test_run_detect();
        bit pat [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        enter_run();
        for (int i = 0; i < 6; i++) begin
            tick(1, 0, pat[i]);
            n_vec++;
            if (run_alarm !== (RUN_DET && i == 5)) begin
                n_err++;
                $display("FAIL run_det[%0d]: run_alarm=%0b required %0b", i, run_alarm, RUN_DET && i == 5);
            end
        end
        tick(1, 0, 0);
        n_vec++;
        if (run_alarm !== RUN_DET || state !== 2'd2) begin
            n_err++;
            $display("FAIL run_sticky: run_alarm=%0b state=%0d required %0b/2", run_alarm, state, RUN_DET);
        end
        tick(0, 1, 0);
        n_vec++;
        if (run_alarm !== 1'b0) begin
            n_err++;
            $display("FAIL run_clr: run_alarm=%0b required 0", run_alarm);
        end
    endtask

    task automatic test_saturation();
        s_clr = 1'b1;
        @(posedge clk);
        #1 s_clr = 1'b0; s_en = 1'b1; s_mis = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            n_vec++;
            if (s_mis_cnt !== 4'(i + 1)) begin
                n_err++;
                $display("FAIL sat_count[%0d]: mis_cnt=%0d required %0d", i, s_mis_cnt, i + 1);
            end
        end
        n_vec++;
        if (s_state !== 2'd3 || s_win_cnt !== 4'd15 || s_win_done !== 1'b1 || s_alarm !== 1'b1) begin
            n_err++;
            $display("FAIL sat_window: state=%0d win_cnt=%0d win_done=%0b alarm=%0b required 3/15/1/1", s_state, s_win_cnt, s_win_done, s_alarm);
        end
        repeat (4) @(posedge clk);
        #1;
        n_vec++;
        if (s_mis_cnt !== 4'd15 || s_state !== 2'd3 || s_run_alarm !== RUN_DET) begin
            n_err++;
            $display("FAIL sat_hold: mis_cnt=%0d state=%0d run_alarm=%0b required 15/3/%0b", s_mis_cnt, s_state, s_run_alarm, RUN_DET);
        end
        s_en = 1'b0; s_mis = 1'b0; s_clr = 1'b1;
        @(posedge clk);
        #1 s_clr = 1'b0;
    endtask

    task automatic test_random();
        logic [CNT_W*2+4:0] exp_v, got_v;
        tick(0, 1, 0);
        for (int i = 0; i < 3000; i++) begin
            tick($urandom_range(0, 19) != 0, $urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0);
            exp_v = {CNT_W'(m_total), CNT_W'(m_last_win), m_done, (m_mode == 3), 2'(m_mode), m_streak_alarm};
            got_v = {mis_cnt, win_cnt, win_done, alarm, state, run_alarm};
            n_vec++;
            if (got_v !== exp_v) begin
                n_err++;
                $display("FAIL random[%0d]: {mis_cnt,win_cnt,done,alarm,state,run}=%h required %h", i, got_v, exp_v);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fill_ignore();
        test_alarm_window();
        test_en_drop();
        test_run_detect();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
